// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: sequencer for a bank of single-pulse channel generators.
// On each accepted launch, it walks the enabled channels in ascending order.
// For each channel it waits that channel's pre-delay, then holds its start
// line until the channel reports done. The whole pattern repeats reps times,
// with an inter-burst gap between repetitions.
// Optional build macro: PULSE_SEQ_TIMEOUT_EN adds a per-channel hang timeout.
// A hang sets the sticky err flag and the sequence moves on.
module pulse_seq_ctrl #(
  parameter int N_CH      = 4,
  parameter int DW        = 36,
  parameter int RW        = 16,
  parameter int TO_MARGIN = 8
) (
  input  logic                    clk_Pulse,
  input  logic                    rst_n,
  input  logic                    launch,
  input  logic                    abort,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [DW-1:0]           cfg_delay,
  input  logic [DW-1:0]           cfg_dur,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [RW-1:0]           reps,
  input  logic [DW-1:0]           gap,
  input  logic [N_CH-1:0]         ch_done,
  output logic [N_CH-1:0]         ch_start,
  output logic [DW-1:0]           ch_dur,
  output logic                    busy,
  output logic                    seq_done,
  output logic [RW-1:0]           rep_cnt,
  output logic                    err
);

  localparam int CW = $clog2(N_CH);
  // The pointer must be able to hold N_CH, which means "past the last channel".
  localparam int PW = $clog2(N_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_DELAY, S_PULSE, S_RELEASE, S_GAP, S_DONE
  } state_t;

  state_t            state_q;
  logic [DW-1:0]     delay_q [N_CH];
  logic [DW-1:0]     dur_q   [N_CH];
  logic [PW-1:0]     ptr_q;
  logic [DW:0]       cnt_q;
  logic [N_CH-1:0]   en_q;
  logic [RW-1:0]     reps_q;
  logic [DW-1:0]     gap_q;
  logic [RW-1:0]     rep_cnt_q;
  logic              busy_q;
  logic              seq_done_q;
  logic [N_CH-1:0]   ch_start_q;
  logic [DW-1:0]     ch_dur_q;
  logic              launch_q;

  logic              launch_rise;
  logic              found;
  logic [PW-1:0]     found_idx;
  logic [CW-1:0]     sel_ch;
  logic [CW-1:0]     cur_ch;
  logic [DW:0]       cnt_inc;
  logic [RW-1:0]     rep_next;
  logic              pulse_timeout;

  assign launch_rise = launch & ~launch_q;
  assign sel_ch      = found_idx[CW-1:0];
  assign cur_ch      = ptr_q[CW-1:0];
  assign cnt_inc     = cnt_q + (DW+1)'(1);
  assign rep_next    = rep_cnt_q + RW'(1);

  // Lowest enabled channel index at or above the current pointer.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_q[i] && (PW'(i) >= ptr_q)) begin
        found     = 1'b1;
        found_idx = PW'(i);
      end
    end
  end

`ifdef PULSE_SEQ_TIMEOUT_EN
  logic err_q;
  // Hung channel: done not seen within duration plus margin cycles of PULSE.
  assign pulse_timeout = (cnt_inc == ({1'b0, dur_q[cur_ch]} + (DW+1)'(TO_MARGIN)));
  assign err           = err_q;
`else
  assign pulse_timeout = 1'b0;
  assign err           = 1'b0;
`endif

  // Per-channel delay/duration table.
  // Writes are accepted only while idle. An out-of-range cfg_ch matches no
  // channel index, so it is dropped naturally.
  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        delay_q[i] <= '0;
        dur_q[i]   <= '0;
      end
    end else if (cfg_we && (state_q == S_IDLE)) begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_ch == CW'(i)) begin
          delay_q[i] <= cfg_delay;
          dur_q[i]   <= cfg_dur;
        end
      end
    end
  end

  // Sequencer FSM with registered outputs. Abort from any active state wins.
  always_ff @(posedge clk_Pulse or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      en_q       <= '0;
      reps_q     <= '0;
      gap_q      <= '0;
      rep_cnt_q  <= '0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      ch_start_q <= '0;
      ch_dur_q   <= '0;
      launch_q   <= 1'b0;
`ifdef PULSE_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      launch_q   <= launch;
      seq_done_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q    <= S_IDLE;
        ch_start_q <= '0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (launch_rise && !abort) begin
              en_q      <= ch_en;
              reps_q    <= (reps == '0) ? RW'(1) : reps;
              gap_q     <= gap;
              rep_cnt_q <= '0;
              busy_q    <= 1'b1;
              ptr_q     <= '0;
              state_q   <= S_SEL;
`ifdef PULSE_SEQ_TIMEOUT_EN
              err_q     <= 1'b0;
`endif
            end
          end
          S_SEL: begin
            if (found) begin
              ptr_q <= found_idx;
              cnt_q <= '0;
              if (delay_q[sel_ch] == '0) begin
                ch_start_q <= N_CH'(1) << sel_ch;
                ch_dur_q   <= dur_q[sel_ch];
                state_q    <= S_PULSE;
              end else begin
                state_q <= S_DELAY;
              end
            end else begin
              rep_cnt_q <= rep_next;
              if (rep_next < reps_q) begin
                ptr_q <= '0;
                cnt_q <= '0;
                state_q <= (gap_q == '0) ? S_SEL : S_GAP;
              end else begin
                seq_done_q <= 1'b1;
                state_q    <= S_DONE;
              end
            end
          end
          S_DELAY: begin
            if (cnt_inc == {1'b0, delay_q[cur_ch]}) begin
              ch_start_q <= N_CH'(1) << cur_ch;
              ch_dur_q   <= dur_q[cur_ch];
              cnt_q      <= '0;
              state_q    <= S_PULSE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_PULSE: begin
            if (ch_done[cur_ch]) begin
              ch_start_q <= '0;
              state_q    <= S_RELEASE;
            end else if (pulse_timeout) begin
              ch_start_q <= '0;
              state_q    <= S_RELEASE;
`ifdef PULSE_SEQ_TIMEOUT_EN
              err_q      <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_RELEASE: begin
            ptr_q   <= ptr_q + PW'(1);
            state_q <= S_SEL;
          end
          S_GAP: begin
            if (cnt_inc == {1'b0, gap_q}) begin
              ptr_q   <= '0;
              state_q <= S_SEL;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ch_start = ch_start_q;
  assign ch_dur   = ch_dur_q;
  assign busy     = busy_q;
  assign seq_done = seq_done_q;
  assign rep_cnt  = rep_cnt_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// tb_pulse_seq_ctrl: directed bench for pulse_seq_ctrl.
// It includes a behavioural channel-generator model that returns done after
// the configured duration. Event times are measured in clock edges after the
// edge that samples launch.
module tb_pulse_seq_ctrl;
  localparam int N_CH = 4;
  localparam int DW   = 36;
  localparam int RW   = 16;

  logic            clk_Pulse = 1'b0;
  logic            rst_n     = 1'b0;
  logic            launch    = 1'b0;
  logic            abort     = 1'b0;
  logic            cfg_we    = 1'b0;
  logic [1:0]      cfg_ch    = '0;
  logic [DW-1:0]   cfg_delay = '0;
  logic [DW-1:0]   cfg_dur   = '0;
  logic [N_CH-1:0] ch_en     = '0;
  logic [RW-1:0]   reps      = '0;
  logic [DW-1:0]   gap       = '0;
  logic [N_CH-1:0] ch_done;
  logic [N_CH-1:0] ch_start;
  logic [DW-1:0]   ch_dur;
  logic            busy;
  logic            seq_done;
  logic [RW-1:0]   rep_cnt;
  logic            err;

  always #5 clk_Pulse = ~clk_Pulse;

  pulse_seq_ctrl #(.N_CH(N_CH), .DW(DW), .RW(RW), .TO_MARGIN(8)) dut (
    .clk_Pulse(clk_Pulse), .rst_n(rst_n), .launch(launch), .abort(abort),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .cfg_dur(cfg_dur),
    .ch_en(ch_en), .reps(reps), .gap(gap), .ch_done(ch_done),
    .ch_start(ch_start), .ch_dur(ch_dur), .busy(busy), .seq_done(seq_done),
    .rep_cnt(rep_cnt), .err(err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_Pulse) cyc <= cyc + 1;

  // Channel generator model.
  // A channel counts the cycles its start line is seen high and raises done
  // once the count reaches its duration. It clears when start drops.
  // mdl_hang suppresses done.
  int              mdl_dur [N_CH] = '{5, 3, 1, 2};
  int              mdl_cnt [N_CH] = '{0, 0, 0, 0};
  logic            mdl_hang = 1'b0;
  logic [N_CH-1:0] done_r   = '0;
  assign ch_done = done_r;

  always @(posedge clk_Pulse) begin
    for (int i = 0; i < N_CH; i++) begin
      if (ch_start[i]) begin
        mdl_cnt[i] <= mdl_cnt[i] + 1;
        done_r[i]  <= !mdl_hang && (mdl_cnt[i] + 1 >= mdl_dur[i]);
      end else begin
        mdl_cnt[i] <= 0;
        done_r[i]  <= 1'b0;
      end
    end
  end

  // Event monitor: start rises (cycle, index, duration), last fall, seq_done pulses.
  logic [N_CH-1:0] start_prev = '0;
  int rise_cyc[$];
  int rise_idx[$];
  int rise_dur[$];
  int fall_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;

  always @(negedge clk_Pulse) begin
    for (int i = 0; i < N_CH; i++) begin
      if (ch_start[i] && !start_prev[i]) begin
        rise_cyc.push_back(cyc);
        rise_idx.push_back(i);
        rise_dur.push_back(int'(ch_dur));
      end
      if (!ch_start[i] && start_prev[i]) fall_cyc = cyc;
    end
    if (seq_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    start_prev = ch_start;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic int q_at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_Pulse);
    #1;
  endtask

  task automatic clear_log();
    rise_cyc.delete();
    rise_idx.delete();
    rise_dur.delete();
    fall_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic cfg_write(input int ch, input int d, input int u);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_delay = DW'(d);
    cfg_dur   = DW'(u);
    tick(1);
    cfg_we    = 1'b0;
  endtask

  // One-cycle launch pulse; e returns the cycle number of the sampling edge.
  task automatic do_launch(output int e);
    launch = 1'b1;
    tick(1);
    e = cyc;
    launch = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick(1);
      n++;
    end
    check_val({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_start"}, ch_start, 0);
    check_val({tag, "_dur"}, ch_dur, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, seq_done, 0);
    check_val({tag, "_rep"}, rep_cnt, 0);
    check_val({tag, "_err"}, err, 0);
  endtask

  initial begin
    int e;
    int exp_idx[4];
    int exp_off[4];

    // Reset state.
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(1);

    // Single channel: delay 3, duration 5.
    cfg_write(0, 3, 5);
    ch_en = 4'b0001; reps = 1; gap = 0;
    clear_log();
    do_launch(e);
    check_val("t1_busy_on", busy, 1);
    wait_idle("t1", 100);
    check_val("t1_nrise", rise_cyc.size(), 1);
    check_val("t1_idx", q_at(rise_idx, 0), 0);
    check_val("t1_rise_off", q_at(rise_cyc, 0) - e, 4);
    check_val("t1_chdur", q_at(rise_dur, 0), 5);
    check_val("t1_fall_off", fall_cyc - e, 10);
    check_val("t1_ndone", done_cnt, 1);
    check_val("t1_done_off", done_cyc - e, 12);
    check_val("t1_rep", rep_cnt, 1);

    // Two channels, two repetitions, gap 4.
    cfg_write(1, 0, 3);
    cfg_write(3, 2, 2);
    ch_en = 4'b1010; reps = 2; gap = 4;
    clear_log();
    do_launch(e);
    wait_idle("t2", 200);
    exp_idx = '{1, 3, 1, 3};
    exp_off = '{1, 9, 19, 27};
    check_val("t2_nrise", rise_cyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("t2_idx%0d", k), q_at(rise_idx, k), exp_idx[k]);
      check_val($sformatf("t2_off%0d", k), q_at(rise_cyc, k) - e, exp_off[k]);
    end
    check_val("t2_ndone", done_cnt, 1);
    check_val("t2_done_off", done_cyc - e, 32);
    check_val("t2_rep", rep_cnt, 2);

    // Abort while channel 1 is in PULSE.
    mdl_hang = 1'b1;
    ch_en = 4'b0010; reps = 1; gap = 0;
    clear_log();
    do_launch(e);
    tick(2);
    check_val("t3_pulse", ch_start, 4'b0010);
    check_val("t3_busy", busy, 1);
    abort = 1'b1;
    tick(1);
    check_val("t3_ab_start", ch_start, 0);
    check_val("t3_ab_busy", busy, 0);
    check_val("t3_ab_rep", rep_cnt, 0);
    // Abort and a launch edge in the same cycle: launch is not accepted.
    launch = 1'b1;
    tick(1);
    check_val("t3_prio_busy", busy, 0);
    launch = 1'b0; abort = 1'b0;
    tick(1);
    check_val("t3_ab_ndone", done_cnt, 0);
    mdl_hang = 1'b0;
    // Restart from channel 0.
    ch_en = 4'b0011;
    clear_log();
    do_launch(e);
    wait_idle("t3r", 100);
    check_val("t3r_nrise", rise_cyc.size(), 2);
    check_val("t3r_first", q_at(rise_idx, 0), 0);
    check_val("t3r_ndone", done_cnt, 1);

    // Config write and launch edge while busy; launch held after DONE.
    ch_en = 4'b0001;
    clear_log();
    do_launch(e);
    tick(2);
    cfg_write(0, 99, 99);
    launch = 1'b1;
    tick(1);
    wait_idle("t4", 100);
    check_val("t4_ndone", done_cnt, 1);
    check_val("t4_nrise", rise_cyc.size(), 1);
    tick(10);
    check_val("t4_hold_busy", busy, 0);
    check_val("t4_hold_ndone", done_cnt, 1);
    launch = 1'b0;
    tick(1);
    clear_log();
    do_launch(e);
    wait_idle("t4b", 100);
    check_val("t4b_rise_off", q_at(rise_cyc, 0) - e, 4);
    check_val("t4b_chdur", q_at(rise_dur, 0), 5);

    // Empty enable mask, reps=1 and reps=0.
    ch_en = 4'b0000; reps = 1;
    clear_log();
    do_launch(e);
    wait_idle("t5", 20);
    check_val("t5_nrise", rise_cyc.size(), 0);
    check_val("t5_ndone", done_cnt, 1);
    check_val("t5_done_off", done_cyc - e, 1);
    check_val("t5_rep", rep_cnt, 1);
    reps = 0;
    clear_log();
    do_launch(e);
    wait_idle("t5z", 20);
    check_val("t5z_done_off", done_cyc - e, 1);
    check_val("t5z_rep", rep_cnt, 1);

    // Hung channel: duration 4, done never returned.
    cfg_write(0, 3, 4);
    mdl_dur[0] = 4;
    mdl_hang = 1'b1;
    ch_en = 4'b0001; reps = 1;
    clear_log();
    do_launch(e);
`ifdef PULSE_SEQ_TIMEOUT_EN
    tick(15);
    check_val("t6_err_pre", err, 0);
    check_val("t6_start_pre", ch_start, 4'b0001);
    tick(1);
    check_val("t6_err", err, 1);
    check_val("t6_start_drop", ch_start, 0);
    wait_idle("t6", 50);
    check_val("t6_ndone", done_cnt, 1);
    check_val("t6_err_hold", err, 1);
    mdl_hang = 1'b0;
    do_launch(e);
    check_val("t6_err_clr", err, 0);
    wait_idle("t6b", 50);
`else
    tick(40);
    check_val("t6_busy", busy, 1);
    check_val("t6_err", err, 0);
    check_val("t6_start", ch_start, 4'b0001);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_val("t6_ab_busy", busy, 0);
    mdl_hang = 1'b0;
`endif

    // Asynchronous reset in the middle of a pulse.
    clear_log();
    do_launch(e);
    tick(5);
    check_val("t7_pre_start", ch_start, 4'b0001);
    check_val("t7_pre_dur", ch_dur, 4);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t7");
    tick(1);
    rst_n = 1'b1;
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
